// File: rtl/cmd_stream_loader_pkg.sv
// Shared definitions for the command-buffer loader and the buffer top.
// CMD_LOADER_CHECKSUM_EN adds the LOAD_CK state encoding.
package cmd_pkg;
  localparam int INPUTMODE_W = 2;
  localparam int INSTTYPE_W  = 1;

  localparam logic [INPUTMODE_W-1:0] MODE_IDLE = 2'd0;
  localparam logic [INPUTMODE_W-1:0] MODE_CMD  = 2'd1;
  localparam logic [INPUTMODE_W-1:0] MODE_EXEC = 2'd2;

  localparam logic [INSTTYPE_W-1:0] INST_ML = 1'b0;
  localparam logic [INSTTYPE_W-1:0] INST_FE = 1'b1;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_LOAD_ML = 3'd1,
    ST_LOAD_FE = 3'd2,
    ST_EXEC    = 3'd3,
    ST_DONE    = 3'd4,
    ST_ERR     = 3'd5
`ifdef CMD_LOADER_CHECKSUM_EN
    , ST_LOAD_CK = 3'd6
`endif
  } ld_state_e;
endpackage

// File: rtl/cmd_stream_loader_if.sv
// Valid/ready command word stream between host interface and loader.
interface cmd_stream_loader_if #(parameter int CMD_SIZE = 64);
  logic                s_valid;
  logic                s_ready;
  logic [CMD_SIZE-1:0] s_data;
  logic                s_last;

  modport master (output s_valid, s_data, s_last, input s_ready);
  modport slave  (input s_valid, s_data, s_last, output s_ready);
endinterface

// File: rtl/cmd_stream_loader_seg_counter.sv
// Segment word counter: clear/increment with terminal-count flag against a runtime limit.
module cmd_seg_counter #(
  parameter int W = 11
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr_i,
  input  logic         inc_i,
  input  logic [W-1:0] limit_i,
  output logic [W-1:0] cnt_o,
  output logic         tc_o
);
  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i)      cnt_d = '0;
    else if (inc_i) cnt_d = cnt_q + W'(1);
  end

  always_ff @(posedge clk or posedge rst)
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;

  assign cnt_o = cnt_q;
  assign tc_o  = (cnt_q == limit_i);
endmodule

// File: rtl/cmd_stream_loader.sv
// Streams ML then FE command words into the command buffer, then runs it to completion.
// CMD_LOADER_CHECKSUM_EN: a trailing XOR checksum word gates the transition to EXEC.
module cmd_stream_loader
  import cmd_pkg::*;
#(
  parameter int CMD_SIZE = 64,
  parameter int DEPTH_ML = 1024,
  parameter int DEPTH_FE = 2048,
  parameter int ADDR_W   = 11
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  cmd_stream_loader_if.slave     strm,
  output logic [INPUTMODE_W-1:0] cb_inputmode,
  output logic [INSTTYPE_W-1:0]  cb_insttype,
  output logic [ADDR_W-1:0]      cb_waddr,
  output logic [CMD_SIZE-1:0]    cb_wdata,
  input  logic                   cb_busy,
  output logic                   done,
  output logic                   err,
  output logic [2:0]             state_o
);
  localparam logic [ADDR_W-1:0] LIM_ML = ADDR_W'(DEPTH_ML - 1);
  localparam logic [ADDR_W-1:0] LIM_FE = ADDR_W'(DEPTH_FE - 1);

  ld_state_e              state_q;
  logic [INPUTMODE_W-1:0] mode_q;
  logic [INSTTYPE_W-1:0]  inst_q;
  logic [ADDR_W-1:0]      waddr_q;
  logic [CMD_SIZE-1:0]    wdata_q;
  logic                   done_q, err_q, guard_q;
  logic                   acc, in_seg, seg_last, fmt_ok, wr_ok, cnt_clr, cnt_inc, tc;
  logic [ADDR_W-1:0]      cnt;
`ifdef CMD_LOADER_CHECKSUM_EN
  logic [CMD_SIZE-1:0]    ck_q;
`endif

  assign in_seg = (state_q == ST_LOAD_ML) || (state_q == ST_LOAD_FE);
`ifdef CMD_LOADER_CHECKSUM_EN
  assign strm.s_ready = in_seg || (state_q == ST_LOAD_CK);
  assign seg_last     = 1'b0;  // the checksum word is the final stream word
`else
  assign strm.s_ready = in_seg;
  assign seg_last     = (state_q == ST_LOAD_FE) && tc;
`endif
  assign acc     = strm.s_valid && strm.s_ready;
  assign fmt_ok  = seg_last ? strm.s_last : !strm.s_last;
  assign wr_ok   = acc && in_seg && fmt_ok;
  assign cnt_clr = ((state_q == ST_IDLE) && start) || (wr_ok && tc && (state_q == ST_LOAD_ML));
  assign cnt_inc = wr_ok && !tc;

  cmd_seg_counter #(.W(ADDR_W)) u_cnt (
    .clk     (clk),
    .rst     (rst),
    .clr_i   (cnt_clr),
    .inc_i   (cnt_inc),
    .limit_i ((state_q == ST_LOAD_FE) ? LIM_FE : LIM_ML),
    .cnt_o   (cnt),
    .tc_o    (tc)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      mode_q  <= MODE_IDLE;
      inst_q  <= INST_ML;
      waddr_q <= '0;
      wdata_q <= '0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      guard_q <= 1'b0;
`ifdef CMD_LOADER_CHECKSUM_EN
      ck_q    <= '0;
`endif
    end else begin
      mode_q <= MODE_IDLE;
      done_q <= 1'b0;
      if (wr_ok) begin
        mode_q  <= MODE_CMD;
        inst_q  <= (state_q == ST_LOAD_FE) ? INST_FE : INST_ML;
        waddr_q <= cnt;
        wdata_q <= strm.s_data;
      end
`ifdef CMD_LOADER_CHECKSUM_EN
      if ((state_q == ST_IDLE) && start) ck_q <= '0;
      else if (wr_ok)                    ck_q <= ck_q ^ strm.s_data;
`endif
      case (state_q)
        ST_IDLE: if (start) state_q <= ST_LOAD_ML;
        ST_LOAD_ML:
          if (acc) begin
            if (!fmt_ok) begin
              state_q <= ST_ERR;
              err_q   <= 1'b1;
            end else if (tc) state_q <= ST_LOAD_FE;
          end
        ST_LOAD_FE:
          if (acc) begin
            if (!fmt_ok) begin
              state_q <= ST_ERR;
              err_q   <= 1'b1;
            end else if (tc) begin
`ifdef CMD_LOADER_CHECKSUM_EN
              state_q <= ST_LOAD_CK;
`else
              state_q <= ST_EXEC;
              guard_q <= 1'b1;
`endif
            end
          end
`ifdef CMD_LOADER_CHECKSUM_EN
        ST_LOAD_CK:
          if (acc) begin
            if (strm.s_last && (strm.s_data == ck_q)) begin
              state_q <= ST_EXEC;
              guard_q <= 1'b1;
            end else begin
              state_q <= ST_ERR;
              err_q   <= 1'b1;
            end
          end
`endif
        ST_EXEC: begin
          mode_q <= MODE_EXEC;
          // busy may lag the mode switch by a cycle, so the entry cycle ignores it
          if (guard_q) guard_q <= 1'b0;
          else if (!cb_busy) begin
            state_q <= ST_DONE;
            done_q  <= 1'b1;
          end
        end
        ST_DONE: mode_q <= MODE_EXEC;
        ST_ERR:  ;
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign cb_inputmode = mode_q;
  assign cb_insttype  = inst_q;
  assign cb_waddr     = waddr_q;
  assign cb_wdata     = wdata_q;
  assign done         = done_q;
  assign err          = err_q;
  assign state_o      = state_q;
endmodule

// File: tb/tb_cmd_stream_loader.sv
// Directed bench for cmd_stream_loader with DEPTH_ML=4, DEPTH_FE=6.
module tb_cmd_stream_loader;
  import cmd_pkg::*;
  localparam int CMD_SIZE = 64;
  localparam int DEPTH_ML = 4;
  localparam int DEPTH_FE = 6;
  localparam int ADDR_W   = 3;
`ifdef CMD_LOADER_CHECKSUM_EN
  localparam bit CKEN = 1'b1;
`else
  localparam bit CKEN = 1'b0;
`endif
  localparam logic [63:0] GOOD_CK = 64'h1;  // XOR of 0x10..0x19

  logic                   clk = 1'b0;
  logic                   rst, start, cb_busy;
  logic [INPUTMODE_W-1:0] cb_inputmode;
  logic [INSTTYPE_W-1:0]  cb_insttype;
  logic [ADDR_W-1:0]      cb_waddr;
  logic [CMD_SIZE-1:0]    cb_wdata;
  logic                   done, err;
  logic [2:0]             state_o;
  int checks = 0;
  int errors = 0;

  cmd_stream_loader_if #(.CMD_SIZE(CMD_SIZE)) strm ();

  cmd_stream_loader #(
    .CMD_SIZE(CMD_SIZE), .DEPTH_ML(DEPTH_ML), .DEPTH_FE(DEPTH_FE), .ADDR_W(ADDR_W)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .strm(strm),
    .cb_inputmode(cb_inputmode), .cb_insttype(cb_insttype),
    .cb_waddr(cb_waddr), .cb_wdata(cb_wdata), .cb_busy(cb_busy),
    .done(done), .err(err), .state_o(state_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, ".state"}, 64'(state_o), 64'(ST_IDLE));
    chk({tag, ".mode"},  64'(cb_inputmode), 64'(MODE_IDLE));
    chk({tag, ".inst"},  64'(cb_insttype), 64'(INST_ML));
    chk({tag, ".waddr"}, 64'(cb_waddr), 64'd0);
    chk({tag, ".wdata"}, cb_wdata, 64'd0);
    chk({tag, ".ready"}, 64'(strm.s_ready), 64'd0);
    chk({tag, ".done"},  64'(done), 64'd0);
    chk({tag, ".err"},   64'(err), 64'd0);
  endtask

  task automatic do_reset();
    rst = 1'b1; start = 1'b0; cb_busy = 1'b1;
    strm.s_valid = 1'b0; strm.s_last = 1'b0; strm.s_data = '0;
    tick();
    rst = 1'b0;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic send_word(input logic [63:0] data, input logic last);
    strm.s_valid = 1'b1; strm.s_data = data; strm.s_last = last;
    tick();
    strm.s_valid = 1'b0; strm.s_last = 1'b0;
  endtask

  // word i of the 10-word load: expected write presented right after its accept edge
  task automatic send_checked(input int i, input logic last);
    send_word(64'h10 + 64'(i), last);
    chk($sformatf("w%0d.mode", i), 64'(cb_inputmode), 64'(MODE_CMD));
    chk($sformatf("w%0d.inst", i), 64'(cb_insttype), (i < DEPTH_ML) ? 64'(INST_ML) : 64'(INST_FE));
    chk($sformatf("w%0d.addr", i), 64'(cb_waddr), (i < DEPTH_ML) ? 64'(i) : 64'(i - DEPTH_ML));
    chk($sformatf("w%0d.data", i), cb_wdata, 64'h10 + 64'(i));
  endtask

  task automatic load_stream(input logic [63:0] ckw);
    for (int i = 0; i < 10; i++) send_checked(i, (i == 9) && !CKEN);
    if (CKEN) begin
      send_word(ckw, 1'b1);
      chk("ck.nowrite", 64'(cb_inputmode), 64'(MODE_IDLE));
    end
  endtask

  task automatic finish_exec(input string tag);
    cb_busy = 1'b0;
    chk({tag, ".exec"}, 64'(state_o), 64'(ST_EXEC));
    tick();
    chk({tag, ".mode_exec"}, 64'(cb_inputmode), 64'(MODE_EXEC));
    chk({tag, ".guard"}, 64'(done), 64'd0);
    tick();
    chk({tag, ".done"}, 64'(done), 64'd1);
    chk({tag, ".st_done"}, 64'(state_o), 64'(ST_DONE));
  endtask

  initial begin
    logic pat [4];
    int   idx;
    pat = '{1'b1, 1'b0, 1'b0, 1'b1};

    // 1: nominal
    do_reset();
    chk_reset("rst");
    pulse_start();
    chk("s1.state", 64'(state_o), 64'(ST_LOAD_ML));
    chk("s1.ready", 64'(strm.s_ready), 64'd1);
    load_stream(GOOD_CK);
    chk("s1.exec", 64'(state_o), 64'(ST_EXEC));
    chk("s1.ready_exec", 64'(strm.s_ready), 64'd0);
    tick();
    chk("s1.mode_exec", 64'(cb_inputmode), 64'(MODE_EXEC));
    for (int c = 0; c < 4; c++) begin
      tick();
      chk("s1.busy_hold", 64'(done), 64'd0);
    end
    cb_busy = 1'b0;
    tick();
    chk("s1.done", 64'(done), 64'd1);
    chk("s1.st_done", 64'(state_o), 64'(ST_DONE));
    tick();
    chk("s1.done_once", 64'(done), 64'd0);
    chk("s1.mode_hold", 64'(cb_inputmode), 64'(MODE_EXEC));
    pulse_start();
    chk("s1.start_ign", 64'(state_o), 64'(ST_DONE));

    // 2: backpressure
    do_reset();
    pulse_start();
    idx = 0;
    for (int cyc = 0; cyc < 40 && idx < 10; cyc++) begin
      if (pat[cyc % 4]) begin
        send_checked(idx, (idx == 9) && !CKEN);
        idx++;
      end else begin
        tick();
        chk("s2.idle", 64'(cb_inputmode), 64'(MODE_IDLE));
      end
    end
    chk("s2.count", 64'(idx), 64'd10);
    if (CKEN) send_word(GOOD_CK, 1'b1);
    finish_exec("s2");

    // 3: early s_last on word 3
    do_reset();
    pulse_start();
    for (int i = 0; i < 3; i++) send_checked(i, 1'b0);
    send_word(64'h13, 1'b1);
    chk("s3.err", 64'(err), 64'd1);
    chk("s3.state", 64'(state_o), 64'(ST_ERR));
    chk("s3.ready", 64'(strm.s_ready), 64'd0);
    chk("s3.nowrite", 64'(cb_inputmode), 64'(MODE_IDLE));
    chk("s3.wdata", cb_wdata, 64'h12);
    pulse_start();
    chk("s3.sticky", 64'(state_o), 64'(ST_ERR));

    // 4: final word without s_last
    do_reset();
    pulse_start();
    for (int i = 0; i < 9; i++) send_checked(i, 1'b0);
    if (CKEN) begin
      send_checked(9, 1'b0);
      send_word(GOOD_CK, 1'b0);
    end else begin
      send_word(64'h19, 1'b0);
    end
    chk("s4.state", 64'(state_o), 64'(ST_ERR));
    chk("s4.err", 64'(err), 64'd1);
    chk("s4.nowrite", 64'(cb_inputmode), 64'(MODE_IDLE));
    cb_busy = 1'b0;
    for (int c = 0; c < 3; c++) begin
      tick();
      chk("s4.noexec", 64'(cb_inputmode), 64'(MODE_IDLE));
    end

    // 5: reset mid-FE, then a clean load
    do_reset();
    pulse_start();
    for (int i = 0; i < 6; i++) send_checked(i, 1'b0);
    rst = 1'b1;
    #1;
    chk_reset("s5.async");
    tick();
    rst = 1'b0;
    pulse_start();
    load_stream(GOOD_CK);
    finish_exec("s5");

`ifdef CMD_LOADER_CHECKSUM_EN
    // 6: bad checksum
    do_reset();
    pulse_start();
    load_stream(GOOD_CK ^ 64'h1);
    chk("s6.err", 64'(err), 64'd1);
    chk("s6.state", 64'(state_o), 64'(ST_ERR));
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
